// File: rtl/dds_serial_rx.sv
// Receive side of the DDS serial-load interface: oversamples word_clk/data/fqud, assembles 40-bit LSB-first frames.
// Optional build macro DDS_RX_FRAMECNT_EN adds a valid-frame counter on rd_sel=3 and moves status to frame_cnt_status.
module dds_serial_rx #(
    parameter int WORD_BITS   = 40,
    parameter int SYNC_STAGES = 2
) (
    input  logic        dds_clk,
    input  logic        dds_reset,
    input  logic        ddswclk,
    input  logic        ddsdata,
    input  logic        ddsfqud,
    input  logic        ddsreset,
    input  logic [1:0]  rd_sel,
    output logic [15:0] rd_data,
    output logic [31:0] freq_word,
    output logic [7:0]  ctrl_byte,
    output logic        word_valid,
    output logic        frame_err,
`ifdef DDS_RX_FRAMECNT_EN
    output logic [15:0] frame_cnt_status,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [5:0] FULL_CNT = 6'(WORD_BITS);
    localparam logic [5:0] OVER_CNT = 6'(WORD_BITS + 1);

    logic [SYNC_STAGES-1:0] wclk_sync_q, wclk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic [SYNC_STAGES-1:0] fqud_sync_q, fqud_sync_d;
    logic [SYNC_STAGES-1:0] clr_sync_q,  clr_sync_d;
    logic                   wclk_prev_q, wclk_prev_d;
    logic                   fqud_prev_q, fqud_prev_d;

    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    state_t                 state_q, state_d;
    logic                   ok_q, ok_d;
    logic                   err_q, err_d;
    logic [31:0]            freq_q, freq_d;
    logic [7:0]             ctrl_q, ctrl_d;
    logic                   word_valid_q, word_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic [15:0]            rd_data_q, rd_data_d;
    logic [15:0]            status;
`ifdef DDS_RX_FRAMECNT_EN
    logic [15:0]            frame_cnt_q, frame_cnt_d;
`endif

    logic wclk_edge;
    logic fqud_edge;
    logic data_bit;
    logic clr;

    assign wclk_edge = wclk_sync_q[SYNC_STAGES-1] & ~wclk_prev_q;
    assign fqud_edge = fqud_sync_q[SYNC_STAGES-1] & ~fqud_prev_q;
    assign data_bit  = data_sync_q[SYNC_STAGES-1];
    assign clr       = clr_sync_q[SYNC_STAGES-1];
    assign status    = {ok_q, err_q, 8'h00, bit_cnt_q};

    always_comb begin
        wclk_sync_d = {wclk_sync_q[SYNC_STAGES-2:0], ddswclk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ddsdata};
        fqud_sync_d = {fqud_sync_q[SYNC_STAGES-2:0], ddsfqud};
        clr_sync_d  = {clr_sync_q[SYNC_STAGES-2:0], ddsreset};
        wclk_prev_d = wclk_sync_q[SYNC_STAGES-1];
        fqud_prev_d = fqud_sync_q[SYNC_STAGES-1];
    end

    // Frame assembly; a coincident fqud sees the count and shift value updated by the same-cycle wclk edge.
    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        state_d      = state_q;
        ok_d         = ok_q;
        err_d        = err_q;
        freq_d       = freq_q;
        ctrl_d       = ctrl_q;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (clr) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            state_d   = IDLE;
            ok_d      = 1'b0;
            err_d     = 1'b0;
        end else begin
            if (wclk_edge) begin
                shift_d = {data_bit, shift_q[WORD_BITS-1:1]};
                if (bit_cnt_q != OVER_CNT) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
                case (state_q)
                    IDLE, SHIFT: state_d = (bit_cnt_d == FULL_CNT) ? FULL : SHIFT;
                    FULL:        state_d = OVER;
                    default:     state_d = OVER;
                endcase
            end
            if (fqud_edge) begin
                if (bit_cnt_d == FULL_CNT) begin
                    freq_d       = shift_d[31:0];
                    ctrl_d       = shift_d[39:32];
                    word_valid_d = 1'b1;
                    ok_d         = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                    err_d       = 1'b1;
                end
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
        end
    end

    always_comb begin
`ifdef DDS_RX_FRAMECNT_EN
        frame_cnt_d = frame_cnt_q;
        if (word_valid_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
`endif
        case (rd_sel)
            2'd0:    rd_data_d = freq_q[15:0];
            2'd1:    rd_data_d = freq_q[31:16];
            2'd2:    rd_data_d = {8'h00, ctrl_q};
`ifdef DDS_RX_FRAMECNT_EN
            default: rd_data_d = frame_cnt_q;
`else
            default: rd_data_d = status;
`endif
        endcase
    end

    always_ff @(posedge dds_clk or posedge dds_reset) begin
        if (dds_reset) begin
            wclk_sync_q  <= '0;
            data_sync_q  <= '0;
            fqud_sync_q  <= '0;
            clr_sync_q   <= '0;
            wclk_prev_q  <= 1'b0;
            fqud_prev_q  <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            state_q      <= IDLE;
            ok_q         <= 1'b0;
            err_q        <= 1'b0;
            freq_q       <= '0;
            ctrl_q       <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rd_data_q    <= '0;
`ifdef DDS_RX_FRAMECNT_EN
            frame_cnt_q  <= '0;
`endif
        end else begin
            wclk_sync_q  <= wclk_sync_d;
            data_sync_q  <= data_sync_d;
            fqud_sync_q  <= fqud_sync_d;
            clr_sync_q   <= clr_sync_d;
            wclk_prev_q  <= wclk_prev_d;
            fqud_prev_q  <= fqud_prev_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            state_q      <= state_d;
            ok_q         <= ok_d;
            err_q        <= err_d;
            freq_q       <= freq_d;
            ctrl_q       <= ctrl_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            rd_data_q    <= rd_data_d;
`ifdef DDS_RX_FRAMECNT_EN
            frame_cnt_q  <= frame_cnt_d;
`endif
        end
    end

    assign rd_data    = rd_data_q;
    assign freq_word  = freq_q;
    assign ctrl_byte  = ctrl_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);
`ifdef DDS_RX_FRAMECNT_EN
    assign frame_cnt_status = status;
`endif

endmodule

// File: tb/tb_dds_serial_rx.sv
// Self-checking bench for dds_serial_rx: serial frames are driven from tasks, expected pulses go through a scoreboard queue.
module tb_dds_serial_rx;

    logic        dds_clk;
    logic        dds_reset;
    logic        ddswclk;
    logic        ddsdata;
    logic        ddsfqud;
    logic        ddsreset;
    logic [1:0]  rd_sel;
    logic [15:0] rd_data;
    logic [31:0] freq_word;
    logic [7:0]  ctrl_byte;
    logic        word_valid;
    logic        frame_err;
    logic        busy;
`ifdef DDS_RX_FRAMECNT_EN
    logic [15:0] frame_cnt_status;
`endif

    int checks = 0;
    int errors = 0;
    int valid_pulses = 0;
    int err_pulses = 0;

    typedef struct {
        bit          is_err;
        logic [39:0] word;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;

    dds_serial_rx #(.WORD_BITS(40), .SYNC_STAGES(2)) dut (
        .dds_clk    (dds_clk),
        .dds_reset  (dds_reset),
        .ddswclk    (ddswclk),
        .ddsdata    (ddsdata),
        .ddsfqud    (ddsfqud),
        .ddsreset   (ddsreset),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .freq_word  (freq_word),
        .ctrl_byte  (ctrl_byte),
        .word_valid (word_valid),
        .frame_err  (frame_err),
`ifdef DDS_RX_FRAMECNT_EN
        .frame_cnt_status (frame_cnt_status),
`endif
        .busy       (busy)
    );

    initial begin
        dds_clk = 1'b0;
        forever #5 dds_clk = ~dds_clk;
    end

    // Scoreboard consumer: every output pulse must match the next queued expectation.
    always @(negedge dds_clk) begin
        if (word_valid) valid_pulses++;
        if (frame_err) err_pulses++;
        if (word_valid || frame_err) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got valid=%b err=%b, required no pulse", word_valid, frame_err);
            end else begin
                sb_e = sb_q.pop_front();
                if (word_valid !== !sb_e.is_err || frame_err !== sb_e.is_err) begin
                    errors++;
                    $display("[TB] FAIL sb_kind: got valid=%b err=%b, required err=%b", word_valid, frame_err, sb_e.is_err);
                end else if (!sb_e.is_err && {ctrl_byte, freq_word} !== sb_e.word) begin
                    errors++;
                    $display("[TB] FAIL sb_word: got %h, required %h", {ctrl_byte, freq_word}, sb_e.word);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge dds_clk);
    endtask

    task automatic send_bit(input logic b);
        ddsdata = b;
        wait_cycles(4);
        ddswclk = 1'b1;
        wait_cycles(4);
        ddswclk = 1'b0;
    endtask

    task automatic send_bits(input logic [39:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit((i < 40) ? w[i] : 1'b0);
        end
    endtask

    task automatic pulse_fqud(input bit expect_err, input logic [39:0] w);
        exp_t e;
        e.is_err = expect_err;
        e.word   = w;
        sb_q.push_back(e);
        ddsfqud = 1'b1;
        wait_cycles(4);
        ddsfqud = 1'b0;
        wait_cycles(6);
    endtask

    task automatic read_status(output logic [15:0] s);
`ifdef DDS_RX_FRAMECNT_EN
        wait_cycles(1);
        s = frame_cnt_status;
`else
        rd_sel = 2'd3;
        wait_cycles(2);
        s = rd_data;
`endif
    endtask

    task automatic read_sel(input logic [1:0] sel, output logic [15:0] v);
        rd_sel = sel;
        wait_cycles(2);
        v = rd_data;
    endtask

    task automatic test_reset();
        logic [15:0] s;
        checks++;
        if ({freq_word, ctrl_byte, word_valid, frame_err, busy, rd_data} !== 59'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h, required 0", {freq_word, ctrl_byte, word_valid, frame_err, busy, rd_data});
        end
        dds_reset = 1'b0;
        wait_cycles(3);
        read_status(s);
        checks++;
        if (s !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h, required 0000", s);
        end
    endtask

    task automatic test_loopback();
        logic [15:0] v;
        int vp;
        vp = valid_pulses;
        send_bits({8'h01, 32'h1234_5678}, 40);
        pulse_fqud(1'b0, {8'h01, 32'h1234_5678});
        checks++;
        if (valid_pulses - vp !== 1) begin
            errors++;
            $display("[TB] FAIL loop_pulses: got %0d, required 1", valid_pulses - vp);
        end
        checks++;
        if (freq_word !== 32'h1234_5678 || ctrl_byte !== 8'h01) begin
            errors++;
            $display("[TB] FAIL loop_word: got %h/%h, required 12345678/01", freq_word, ctrl_byte);
        end
        read_sel(2'd0, v);
        checks++;
        if (v !== 16'h5678) begin
            errors++;
            $display("[TB] FAIL loop_rd0: got %h, required 5678", v);
        end
        read_sel(2'd1, v);
        checks++;
        if (v !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL loop_rd1: got %h, required 1234", v);
        end
        read_sel(2'd2, v);
        checks++;
        if (v !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL loop_rd2: got %h, required 0001", v);
        end
    endtask

    task automatic test_short_frame();
        logic [15:0] s;
        send_bits(40'hAB_CDEF_0123, 39);
        pulse_fqud(1'b1, 40'h0);
        checks++;
        if (freq_word !== 32'h1234_5678 || ctrl_byte !== 8'h01) begin
            errors++;
            $display("[TB] FAIL short_hold: got %h/%h, required 12345678/01", freq_word, ctrl_byte);
        end
        read_status(s);
        checks++;
        if (s !== 16'hC000) begin
            errors++;
            $display("[TB] FAIL short_status: got %h, required c000", s);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL short_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_overlong();
        logic [15:0] s;
        int vp;
        vp = valid_pulses;
        send_bits(40'h11_2233_4455, 42);
        wait_cycles(4);
        read_status(s);
        checks++;
        if (s[5:0] !== 6'd41 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL over_state: got cnt=%0d busy=%b, required cnt=41 busy=1", s[5:0], busy);
        end
        pulse_fqud(1'b1, 40'h0);
        checks++;
        if (valid_pulses - vp !== 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL over_novalid: got %0d pulses busy=%b, required 0 pulses busy=0", valid_pulses - vp, busy);
        end
    endtask

    task automatic test_ddsreset();
        logic [15:0] s;
        send_bits(40'h77_8899_AABB, 20);
        ddsreset = 1'b1;
        wait_cycles(3);
        ddsreset = 1'b0;
        wait_cycles(4);
        read_status(s);
        checks++;
        if (s !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ddsrst_clear: got status=%h busy=%b, required 0000/0", s, busy);
        end
        checks++;
        if (freq_word !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL ddsrst_hold: got %h, required 12345678", freq_word);
        end
        send_bits(40'hFF_0000_0001, 40);
        pulse_fqud(1'b0, 40'hFF_0000_0001);
        checks++;
        if (freq_word !== 32'h0000_0001 || ctrl_byte !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL ddsrst_word: got %h/%h, required 00000001/ff", freq_word, ctrl_byte);
        end
    endtask

    task automatic test_coincident();
        logic [39:0] w;
        int vp;
        w  = 40'h80_A5A5_5A5A;
        vp = valid_pulses;
        send_bits(w, 39);
        ddsdata = w[39];
        wait_cycles(4);
        sb_q.push_back('{is_err: 1'b0, word: w});
        ddswclk = 1'b1;
        ddsfqud = 1'b1;
        wait_cycles(4);
        ddswclk = 1'b0;
        ddsfqud = 1'b0;
        wait_cycles(6);
        checks++;
        if (valid_pulses - vp !== 1 || ctrl_byte !== 8'h80) begin
            errors++;
            $display("[TB] FAIL coinc_word: got %0d pulses ctrl=%h, required 1 pulse ctrl=80", valid_pulses - vp, ctrl_byte);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] s;
        int vp, ep;
        send_bits(40'h12_3456_789A, 10);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_busy: got %b, required 1", busy);
        end
        rd_sel = 2'd1;
        wait_cycles(2);
        vp = valid_pulses;
        ep = err_pulses;
        #2 dds_reset = 1'b1;
        #1;
        checks++;
        if ({freq_word, ctrl_byte, word_valid, frame_err, busy, rd_data} !== 59'h0) begin
            errors++;
            $display("[TB] FAIL async_outputs: got %h, required 0", {freq_word, ctrl_byte, word_valid, frame_err, busy, rd_data});
        end
        wait_cycles(2);
        dds_reset = 1'b0;
        wait_cycles(6);
        checks++;
        if (valid_pulses != vp || err_pulses != ep) begin
            errors++;
            $display("[TB] FAIL async_pulses: got %0d/%0d, required 0/0", valid_pulses - vp, err_pulses - ep);
        end
`ifdef DDS_RX_FRAMECNT_EN
        read_sel(2'd3, s);
        checks++;
        if (s !== 16'd0) begin
            errors++;
            $display("[TB] FAIL async_cnt0: got %0d, required 0", s);
        end
`else
        read_status(s);
        checks++;
        if (s !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL async_status: got %h, required 0000", s);
        end
`endif
        send_bits(40'h3C_DEAD_BEEF, 40);
        pulse_fqud(1'b0, 40'h3C_DEAD_BEEF);
        send_bits(40'h5A_0BAD_F00D, 40);
        pulse_fqud(1'b0, 40'h5A_0BAD_F00D);
`ifdef DDS_RX_FRAMECNT_EN
        read_sel(2'd3, s);
        checks++;
        if (s !== 16'd2) begin
            errors++;
            $display("[TB] FAIL async_cnt2: got %0d, required 2", s);
        end
`else
        read_sel(2'd1, s);
        checks++;
        if (s !== 16'h0BAD) begin
            errors++;
            $display("[TB] FAIL async_rd1: got %h, required 0bad", s);
        end
`endif
    endtask

    initial begin
        dds_reset = 1'b1;
        ddswclk   = 1'b0;
        ddsdata   = 1'b0;
        ddsfqud   = 1'b0;
        ddsreset  = 1'b0;
        rd_sel    = 2'd0;
        wait_cycles(3);
        $display("[TB] starting dds_serial_rx tests");
        test_reset();
        test_loopback();
        test_short_frame();
        test_overlong();
        test_ddsreset();
        test_coincident();
        test_async_reset();
        wait_cycles(4);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_leftover: got %0d pending, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_serial_rx.md
Name: dds_serial_rx

Overview:
- Receive end of the DDS serial-load interface: deserializes the word_clk/data/freq_update serial stream that the DDS loader drives to the AD985x-style synthesizer.
- Oversamples the three lines in the dds_clk domain and assembles each 40-bit word: 32-bit frequency tuning word plus 8-bit control/phase byte, LSB first.
- Validates framing and presents the received word on a 16-bit readback bus.
- Used for loopback/readback checking of the DDS loader in the NMR transmitter chain, and as the bench-side DDS model.

Parameters:
- WORD_BITS, 40, serial bits per frame; freq word = bits [31:0], ctrl byte = bits [39:32].
- SYNC_STAGES, 2, synchronizer flops on each serial input (legal range 2..3).

Ports:
- dds_clk  in  1  system clock; must be at least 4x the word_clk rate.
- dds_reset  in  1  asynchronous, active-high reset.
- ddswclk  in  1  serial word clock from the loader; data is sampled on its rising edge.
- ddsdata  in  1  serial data bit.
- ddsfqud  in  1  frequency-update strobe; its rising edge ends the frame.
- ddsreset  in  1  DDS-side reset; synchronous clear of the receiver while high.
- rd_sel  in  2  readback select: 0 = freq[15:0], 1 = freq[31:16], 2 = {8'h00, ctrl}, 3 = {status, bit_cnt}.
- rd_data  out  16  readback mux output, registered.
- freq_word  out  32  last valid frequency tuning word.
- ctrl_byte  out  8  last valid control/phase byte.
- word_valid  out  1  one-cycle pulse when a good frame is latched.
- frame_err  out  1  one-cycle pulse on a short or overlong frame.
- busy  out  1  high while a frame is partially shifted in.

Behaviour:
- Reset values: all outputs, the shift register, bit_cnt and the sticky flags are 0; the state is IDLE.
- Synchronization: each serial input passes through SYNC_STAGES flops, then one edge-detect flop.
- Edge latency: a pin edge is acted on SYNC_STAGES+1 dds_clk cycles after it occurs.
- Shift register:
  - On a wclk rising edge: shift = {bit, shift[39:1]}, so the first bit received ends up in bit 0.
  - bit_cnt is 6 bits and saturates at 41.
- States:
  - IDLE: a wclk edge shifts one bit and moves to SHIFT.
  - SHIFT: a wclk edge shifts one bit. When bit_cnt reaches 40, move to FULL.
  - FULL: a further wclk edge sets bit_cnt to 41 and moves to OVER. Shifting continues, and the last 40 bits are retained.
  - OVER: waits for an fqud edge.
- fqud rising edge, from any state:
  - If bit_cnt == 40: latch freq_word = shift[31:0] and ctrl_byte = shift[39:32], pulse word_valid the next cycle, set sticky ok.
  - Otherwise (including 0 bits): pulse frame_err, set sticky err, leave freq_word and ctrl_byte unchanged.
  - In all cases: clear bit_cnt and return to IDLE.
- Simultaneous wclk and fqud edges in the same cycle: the fqud check uses the count including the coincident bit, and that bit is included in the word.
- busy = (state != IDLE).
- ddsreset high:
  - Synchronously clears the shift register, bit_cnt, state and both sticky flags every cycle it is high.
  - Edges are ignored while it is high.
  - freq_word and ctrl_byte are NOT cleared; they hold the last good word.
- dds_reset asserted mid-frame: immediate return to the reset values; the partial frame is discarded with no pulses.
- status field for rd_sel = 3: bits [15:14] = {ok, err} sticky flags, bits [13:6] = 0, bits [5:0] = bit_cnt.
- rd_data: registered one cycle after rd_sel changes; rd_sel = 3 reflects live bit_cnt.

Optional Feature:
- Macro: DDS_RX_FRAMECNT_EN.
- Defined:
  - Adds a 16-bit wrapping counter of valid frames, incremented on each word_valid.
  - rd_sel = 3 returns the counter instead of status; status moves to output port frame_cnt_status (16 bits).
  - The counter is cleared by dds_reset only.
- Undefined: no counter, and rd_sel = 3 returns status as described above.

Test Plan:
- Loopback check:
  - Stimulus: drive the loader with freq 32'h1234_5678 and ctrl 8'h01 (40 bits, LSB first), then an fqud pulse.
  - Required response: word_valid pulses once; freq_word = 32'h12345678; ctrl_byte = 8'h01; rd_sel = 1 gives 16'h1234; rd_sel = 2 gives 16'h0001.
- Short frame:
  - Stimulus: 39 wclk pulses, then fqud.
  - Required response: frame_err pulses; freq_word keeps its previous value; the status err bit = 1; busy returns to 0.
- Overlong frame:
  - Stimulus: 42 wclk pulses, then fqud.
  - Required response: state OVER seen before the fqud; frame_err pulses; no word_valid.
- ddsreset mid-frame:
  - Stimulus: 20 bits, then ddsreset high for 3 cycles, then a full 40-bit frame of 40'hFF_0000_0001.
  - Required response: after the reset pulse, bit_cnt = 0 and busy = 0; after the frame, freq_word = 32'h00000001 and ctrl_byte = 8'hFF.
- Coincident edges:
  - Stimulus: the 40th wclk edge and the fqud edge arrive in the same sample cycle.
  - Required response: word_valid pulses, with the 40th bit included in the word.
- dds_reset asynchronous assert while busy:
  - Stimulus: assert dds_reset while busy = 1.
  - Required response: all outputs are 0 within the same cycle and no pulses are emitted. With DDS_RX_FRAMECNT_EN, the counter reads 0 afterwards, then 2 after two good frames.
